// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, timer sizing and frame bit indices.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StWaitFirst,
    StShift,
    StAck,
    StWaitIdle,
    StFail
  } ps2_state_e;

  localparam int unsigned TIMER_W = 19;

  localparam logic [3:0] PARITY_IDX = 4'd8;
  localparam logic [3:0] STOP_IDX   = 4'd9;

  function automatic logic [TIMER_W-1:0] us_to_ticks(input int unsigned clk_hz,
                                                     input int unsigned us);
    int unsigned ticks;
    ticks = (clk_hz / 32'd1_000_000) * us;
    return TIMER_W'(ticks);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 pin, accepts a new level only after FILTER_CYCLES
// consistent samples, and strobes on each accepted 1->0 transition.
module ps2_line_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clock_25,
  input  logic RESET_N,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;

  // Idle bus is pulled high, so the synchronizer and level start at 1.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync_q[1];
        fall_q  <= level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits + odd parity + stop
// clocked out by the device, then ack check; lines are driven open-drain via the oe outputs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 25000000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000,
  parameter int unsigned FILTER_CYCLES    = 8
) (
  input  logic       clock_25,
  input  logic       RESET_N,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_block,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [TIMER_W-1:0] INHIBIT_TICKS = us_to_ticks(CLK_HZ, INHIBIT_US);
  localparam logic [TIMER_W-1:0] START_TICKS   = us_to_ticks(CLK_HZ, START_TIMEOUT_US);
  localparam logic [TIMER_W-1:0] FRAME_TICKS   = us_to_ticks(CLK_HZ, FRAME_TIMEOUT_US);

  logic clk_level, clk_fall, dat_level, unused_dat_fall;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clock_25(clock_25),
    .RESET_N (RESET_N),
    .raw     (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_dat_filter (
    .clock_25(clock_25),
    .RESET_N (RESET_N),
    .raw     (ps2_dat_in),
    .level   (dat_level),
    .fall    (unused_dat_fall)
  );

  ps2_state_e         state_q;
  logic [7:0]         data_q;
  logic               parity_q;
  logic [3:0]         idx_q;
  logic [3:0]         idx_nxt;
  logic [TIMER_W-1:0] timer_q;
  logic               busy_q, done_q, error_q, clk_oe_q, dat_oe_q;

  assign idx_nxt = idx_q + 4'd1;

  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      data_q   <= '0;
      parity_q <= 1'b0;
      idx_q    <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (tx_start) begin
            data_q   <= tx_data;
            parity_q <= ~^tx_data;
            busy_q   <= 1'b1;
            error_q  <= 1'b0;
            clk_oe_q <= 1'b1;
            timer_q  <= INHIBIT_TICKS;
            state_q  <= StInhibit;
          end
        end
        StInhibit: begin
          if (timer_q == '0) begin
            dat_oe_q <= 1'b1;
            state_q  <= StStart;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        StStart: begin
          clk_oe_q <= 1'b0;
          timer_q  <= START_TICKS;
          state_q  <= StWaitFirst;
        end
        StWaitFirst: begin
          // The first device falling edge already asks for D0.
          if (clk_fall) begin
            idx_q    <= '0;
            dat_oe_q <= ~data_q[0];
            timer_q  <= FRAME_TICKS;
            state_q  <= StShift;
          end else if (timer_q == '0) begin
            dat_oe_q <= 1'b0;
            state_q  <= StFail;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        StShift: begin
          if (timer_q == '0) begin
            dat_oe_q <= 1'b0;
            state_q  <= StFail;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
            if (clk_fall) begin
              idx_q <= idx_nxt;
              if (idx_nxt == STOP_IDX) begin
                dat_oe_q <= 1'b0;
                state_q  <= StAck;
              end else if (idx_nxt == PARITY_IDX) begin
                dat_oe_q <= ~parity_q;
              end else begin
                dat_oe_q <= ~data_q[idx_nxt[2:0]];
              end
            end
          end
        end
        StAck: begin
          if (timer_q == '0) begin
            state_q <= StFail;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
            if (clk_fall) begin
              state_q <= dat_level ? StFail : StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          if (clk_level && dat_level) begin
            done_q  <= 1'b1;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StFail: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          done_q   <= 1'b1;
          error_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign rx_block   = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// scoreboard of expected outcomes is popped on every done pulse.
module tb_ps2_host_tx;

  // 1 MHz clock rate makes one timer tick per microsecond, keeping timeouts short.
  localparam int unsigned CLK_HZ      = 1_000_000;
  localparam int unsigned FILTER      = 8;
  localparam int unsigned HALF        = 40;
  localparam int          START_TO    = 15000;
  localparam int          WAIT_LIMIT  = 2000;

  logic       clock_25 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, rx_block;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1, dev_dat = 1'b1, glitch_low = 1'b0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe & ~glitch_low;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_HZ       (CLK_HZ),
    .FILTER_CYCLES(FILTER)
  ) dut (
    .clock_25  (clock_25),
    .RESET_N   (RESET_N),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .rx_block  (rx_block),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clock_25 = ~clock_25;

  int cyc = 0;
  always @(posedge clock_25) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic       chk_bits;
    logic [9:0] bits;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0, n_fail = 0;
  int         done_cnt = 0, extra_done = 0, done_cyc = 0, rel_cyc = 0;
  logic [9:0] dev_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock_25) begin : done_monitor
    exp_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        extra_done++;
      end else begin
        e = exp_q.pop_front();
        check("done_error", error, e.err);
        check("busy_at_done", busy, 0);
        check("rx_block_at_done", rx_block, 0);
        if (e.chk_bits) check("frame_bits", dev_bits, e.bits);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic err, input logic chk);
    exp_t e;
    e.err = err;
    e.chk_bits = chk;
    e.bits = {1'b1, ~^b, b};
    exp_q.push_back(e);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clock_25);
    tx_start = 1'b0;
    tx_data  = 8'h5A;
  endtask

  // Device model: observes inhibit/start, then generates n_edges clock pulses and samples
  // the host's data on each rising edge; optional ack, clock glitch and stray tx_start.
  task automatic device(input int n_edges, input bit ack, input bit glitch, input bit extra);
    int t, low, busy_low, cnt0;
    cnt0 = done_cnt;
    busy_low = 0;
    dev_bits = 'x;
    t = 0;
    while (!ps2_clk_oe && t < WAIT_LIMIT) begin @(negedge clock_25); t++; end
    check("inhibit_seen", ps2_clk_oe, 1);
    low = 0;
    while (ps2_clk_oe && !ps2_dat_oe && low < WAIT_LIMIT) begin @(negedge clock_25); low++; end
    check("inhibit_len_ok", (low >= 120), 1);
    check("start_bit", ps2_dat_oe, 1);
    t = 0;
    while (ps2_clk_oe && t < WAIT_LIMIT) begin @(negedge clock_25); t++; end
    rel_cyc = cyc;
    check("clk_released", ps2_clk_oe, 0);
    repeat (50) @(negedge clock_25);
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11) begin
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clock_25);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock_25);
      if (i <= 10) begin
        dev_bits[i-1] = ps2_dat_in;
        if (!busy) busy_low++;
      end
      dev_clk = 1'b1;
      if (glitch && i == 4) begin
        repeat (15) @(negedge clock_25);
        glitch_low = 1'b1;
        repeat (3) @(negedge clock_25);
        glitch_low = 1'b0;
        repeat (HALF - 18) @(negedge clock_25);
      end else begin
        repeat (HALF) @(negedge clock_25);
      end
      if (extra && i == 6) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clock_25);
        tx_start = 1'b0;
      end
    end
    if (n_edges > 0) check("busy_in_frame", busy_low, 0);
    if (n_edges == 11 && ack) check("no_done_before_release", done_cnt, cnt0);
    dev_dat = 1'b1;
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int t;
    t = 0;
    while (done_cnt < target && t < limit) begin @(negedge clock_25); t++; end
    check(tag, done_cnt, target);
  endtask

  initial begin
    int delta, cnt_before;
    repeat (3) @(negedge clock_25);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rx_block", rx_block, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    RESET_N = 1'b1;
    repeat (5) @(negedge clock_25);

    // Normal frames with ACK
    send(8'hED, 1'b0, 1'b1);
    device(11, 1'b1, 1'b0, 1'b0);
    wait_done(1, 300, "done_0xED");

    send(8'h07, 1'b0, 1'b1);
    device(11, 1'b1, 1'b0, 1'b0);
    wait_done(2, 300, "done_0x07");

    // Silent device: start timeout
    send(8'h3C, 1'b1, 1'b0);
    device(0, 1'b1, 1'b0, 1'b0);
    wait_done(3, START_TO + 2000, "done_timeout");
    delta = done_cyc - rel_cyc;
    check("timeout_window", (delta >= START_TO - int'(FILTER) && delta <= START_TO + int'(FILTER)),
          1);
    @(negedge clock_25);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_dat_oe", ps2_dat_oe, 0);

    // NACK
    send(8'hA5, 1'b1, 1'b1);
    device(11, 1'b0, 1'b0, 1'b0);
    wait_done(4, 300, "done_nack");

    // Clock glitch plus stray request while busy
    send(8'h96, 1'b0, 1'b1);
    device(11, 1'b1, 1'b1, 1'b1);
    wait_done(5, 300, "done_glitch");
    repeat (300) @(negedge clock_25);
    check("one_done_per_start", done_cnt, 5);
    check("idle_after_stray", busy, 0);

    // Reset while D4 of 0xEF (a 0, so data driven low) is on the line
    cnt_before = done_cnt;
    tx_data  = 8'hEF;
    tx_start = 1'b1;
    @(negedge clock_25);
    tx_start = 1'b0;
    device(5, 1'b1, 1'b0, 1'b0);
    check("pre_reset_d4", ps2_dat_oe, 1);
    check("pre_reset_busy", busy, 1);
    RESET_N = 1'b0;
    @(negedge clock_25);
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_dat_oe", ps2_dat_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    RESET_N = 1'b1;
    repeat (20) @(negedge clock_25);
    check("midrst_no_done", done_cnt, cnt_before);

    send(8'hFF, 1'b0, 1'b1);
    device(11, 1'b1, 1'b0, 1'b0);
    wait_done(6, 300, "done_0xFF");

    repeat (50) @(negedge clock_25);
    check("extra_done", extra_done, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
